can_bit_stuffer: RTL and testbench

Parametrised CAN bit-stuffing engine with an independent receive destuffer and transmit stuffer sharing one clock and one run-length setting. It replaces the fixed 5-bit, sample-clocked destuffer with a synchronous block driven by a one-cycle bit strobe. It sits between the bit-timing logic, which supplies `i_Sample`, and the frame receiver/transmitter. The receive side flags stuff bits and stuff errors; the transmit side inserts stuff bits with a ready/valid handshake.

---
 rtl/can_bit_stuffer.sv | 155 +++++++++++++++
 tb/tb_can_bit_stuffer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/can_bit_stuffer.sv
// CAN bit stuffer: receive destuffer and transmit stuffer with a shared run length.
// Optional stuff-event counters are built when CAN_STUFF_COUNT_EN is defined.
module can_bit_stuffer #(
  parameter int RUN_LEN = 5
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Sample,
  input  logic       i_Rx_Enable,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_Valid,
  output logic       o_Rx_Bit,
  output logic       o_Ignora_Bit,
  output logic       o_Erro_Stuffing,
  input  logic       i_Tx_Enable,
  input  logic       i_Tx_Valid,
  input  logic       i_Tx_Bit,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Stuffed
`ifdef CAN_STUFF_COUNT_EN
  ,
  output logic [7:0] o_Rx_Stuff_Count,
  output logic [7:0] o_Tx_Stuff_Count
`endif
);

  localparam int              RW      = $clog2(RUN_LEN + 1);
  localparam logic [RW-1:0]   RUN_MAX = RW'(RUN_LEN);

  logic          rx_prev, rx_expect;
  logic [RW-1:0] rx_run, rx_run_nxt;
  logic          tx_prev, tx_pending;
  logic [RW-1:0] tx_run, tx_run_nxt;

  // A run only extends when there is history (run != 0) and the bit repeats.
  always_comb begin
    rx_run_nxt = RW'(1);
    if (rx_run != '0 && i_Rx_Serial == rx_prev) rx_run_nxt = rx_run + RW'(1);
    tx_run_nxt = RW'(1);
    if (tx_run != '0 && i_Tx_Bit == tx_prev) tx_run_nxt = tx_run + RW'(1);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_prev         <= 1'b1;
      rx_run          <= '0;
      rx_expect       <= 1'b0;
      o_Rx_Valid      <= 1'b0;
      o_Rx_Bit        <= 1'b0;
      o_Ignora_Bit    <= 1'b0;
      o_Erro_Stuffing <= 1'b0;
    end else begin
      o_Rx_Valid   <= 1'b0;
      o_Ignora_Bit <= 1'b0;
      if (!i_Rx_Enable) begin
        rx_run    <= '0;
        rx_expect <= 1'b0;
        if (i_Sample) begin
          o_Rx_Valid      <= 1'b1;
          o_Rx_Bit        <= i_Rx_Serial;
          o_Erro_Stuffing <= 1'b0;
          rx_prev         <= i_Rx_Serial;
        end
      end else if (i_Sample) begin
        if (rx_expect) begin
          rx_expect <= 1'b0;
          if (i_Rx_Serial != rx_prev) begin
            o_Ignora_Bit <= 1'b1;
            rx_run       <= RW'(1);
            rx_prev      <= i_Rx_Serial;
          end else begin
            o_Erro_Stuffing <= 1'b1;
            rx_run          <= '0;
          end
        end else begin
          o_Rx_Valid <= 1'b1;
          o_Rx_Bit   <= i_Rx_Serial;
          rx_prev    <= i_Rx_Serial;
          rx_run     <= rx_run_nxt;
          rx_expect  <= (rx_run_nxt == RUN_MAX);
        end
      end
    end
  end

  // o_Tx_Ready is kept as the registered complement of tx_pending.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      tx_prev      <= 1'b1;
      tx_run       <= '0;
      tx_pending   <= 1'b0;
      o_Tx_Ready   <= 1'b1;
      o_Tx_Serial  <= 1'b1;
      o_Tx_Stuffed <= 1'b0;
    end else begin
      o_Tx_Stuffed <= 1'b0;
      if (!i_Tx_Enable) begin
        tx_pending <= 1'b0;
        o_Tx_Ready <= 1'b1;
        tx_run     <= '0;
        if (i_Sample) begin
          o_Tx_Serial <= i_Tx_Valid ? i_Tx_Bit : 1'b1;
          if (i_Tx_Valid) tx_prev <= i_Tx_Bit;
        end
      end else if (i_Sample) begin
        if (tx_pending) begin
          o_Tx_Serial  <= ~tx_prev;
          o_Tx_Stuffed <= 1'b1;
          tx_prev      <= ~tx_prev;
          tx_run       <= RW'(1);
          tx_pending   <= 1'b0;
          o_Tx_Ready   <= 1'b1;
        end else if (i_Tx_Valid) begin
          o_Tx_Serial <= i_Tx_Bit;
          tx_prev     <= i_Tx_Bit;
          tx_run      <= tx_run_nxt;
          if (tx_run_nxt == RUN_MAX) begin
            tx_pending <= 1'b1;
            o_Tx_Ready <= 1'b0;
          end
        end else begin
          o_Tx_Serial <= 1'b1;
          tx_run      <= '0;
        end
      end
    end
  end

`ifdef CAN_STUFF_COUNT_EN
  logic rx_en_d, tx_en_d;
  logic rx_stuff_hit, tx_stuff_hit;

  assign rx_stuff_hit = i_Sample & i_Rx_Enable & rx_expect & (i_Rx_Serial != rx_prev);
  assign tx_stuff_hit = i_Sample & i_Tx_Enable & tx_pending;

  // Saturating counters, cleared when their enable rises.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_en_d          <= 1'b0;
      tx_en_d          <= 1'b0;
      o_Rx_Stuff_Count <= '0;
      o_Tx_Stuff_Count <= '0;
    end else begin
      rx_en_d <= i_Rx_Enable;
      tx_en_d <= i_Tx_Enable;
      if (i_Rx_Enable && !rx_en_d)                      o_Rx_Stuff_Count <= '0;
      else if (rx_stuff_hit && o_Rx_Stuff_Count != 8'hFF) o_Rx_Stuff_Count <= o_Rx_Stuff_Count + 8'd1;
      if (i_Tx_Enable && !tx_en_d)                      o_Tx_Stuff_Count <= '0;
      else if (tx_stuff_hit && o_Tx_Stuff_Count != 8'hFF) o_Tx_Stuff_Count <= o_Tx_Stuff_Count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Directed bench for can_bit_stuffer: RUN_LEN=5 instance plus a RUN_LEN=3 loopback instance.
module tb_can_bit_stuffer;
  logic r_Clock = 1'b0;
  logic rst, sample;
  logic rx_en5, rx_ser5, tx_en5, tx_vld5, tx_bit5;
  logic rx_vld5, rx_bit5, ign5, err5, rdy5, ser5, stf5;
  logic rx_en3, rx_ser3, tx_en3, tx_vld3, tx_bit3;
  logic rx_vld3, rx_bit3, ign3, err3, rdy3, ser3, stf3;
`ifdef CAN_STUFF_COUNT_EN
  logic [7:0] rxc5, txc5, rxc3, txc3;
`endif
  int n_chk = 0, n_pass = 0;

  always #5 r_Clock = ~r_Clock;
  assign rx_ser3 = ser3;

  can_bit_stuffer #(.RUN_LEN(5)) u_dut5 (
    .i_Clock(r_Clock), .i_Reset(rst), .i_Sample(sample),
    .i_Rx_Enable(rx_en5), .i_Rx_Serial(rx_ser5),
    .o_Rx_Valid(rx_vld5), .o_Rx_Bit(rx_bit5), .o_Ignora_Bit(ign5), .o_Erro_Stuffing(err5),
    .i_Tx_Enable(tx_en5), .i_Tx_Valid(tx_vld5), .i_Tx_Bit(tx_bit5),
    .o_Tx_Ready(rdy5), .o_Tx_Serial(ser5), .o_Tx_Stuffed(stf5)
`ifdef CAN_STUFF_COUNT_EN
    , .o_Rx_Stuff_Count(rxc5), .o_Tx_Stuff_Count(txc5)
`endif
  );

  can_bit_stuffer #(.RUN_LEN(3)) u_dut3 (
    .i_Clock(r_Clock), .i_Reset(rst), .i_Sample(sample),
    .i_Rx_Enable(rx_en3), .i_Rx_Serial(rx_ser3),
    .o_Rx_Valid(rx_vld3), .o_Rx_Bit(rx_bit3), .o_Ignora_Bit(ign3), .o_Erro_Stuffing(err3),
    .i_Tx_Enable(tx_en3), .i_Tx_Valid(tx_vld3), .i_Tx_Bit(tx_bit3),
    .o_Tx_Ready(rdy3), .o_Tx_Serial(ser3), .o_Tx_Stuffed(stf3)
`ifdef CAN_STUFF_COUNT_EN
    , .o_Rx_Stuff_Count(rxc3), .o_Tx_Stuff_Count(txc3)
`endif
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One-cycle strobe; outputs are read 1 time unit after the edge.
  task automatic strobe();
    sample = 1'b1;
    @(posedge r_Clock); #1;
    sample = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge r_Clock); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int b1[7] = '{0,0,0,0,0,1,0};
    int e1[7] = '{4,4,4,4,4,2,4};
    int q3[7] = '{1,1,1,1,1,1,0};
    int s3[8] = '{1,1,1,1,1,0,1,0};
    int q4[5] = '{0,0,0,1,1};
    int s4[8] = '{0,0,0,1,1,1,0,1};
    int r4[8] = '{0,4,4,4,2,5,5,2};
    int idx, ign_cnt;
    logic rdy_b;

    rst = 1'b1; sample = 1'b0;
    {rx_en5, rx_ser5, tx_en5, tx_vld5, tx_bit5} = '0;
    {rx_en3, tx_en3, tx_vld3, tx_bit3} = '0;
    repeat (2) @(posedge r_Clock);
    #1 rst = 1'b0;
    check("rst_serial", int'(ser5), 1);
    check("rst_ready",  int'(rdy5), 1);
    check("rst_pulses", int'({rx_vld5, ign5, stf5, err5}), 0);

    // Receive destuff: five zeros, stuff one, data zero
    rx_en5 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rx_ser5 = b1[i][0];
      strobe();
      check($sformatf("rx_basic[%0d]", i), int'({rx_vld5, ign5, rx_vld5 & rx_bit5}), e1[i]);
    end
    check("rx_basic_err", int'(err5), 0);

    // Stuff error, sticky until enable drops
    rx_en5 = 1'b0; idle(1);
    rx_en5 = 1'b1; rx_ser5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      strobe();
      check($sformatf("rx_err_seq[%0d]", i), int'({rx_vld5, ign5}), (i < 5) ? 2 : 0);
    end
    check("rx_err_set", int'(err5), 1);
    idle(3);
    check("rx_err_sticky", int'(err5), 1);
    rx_en5 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe();
      check($sformatf("rx_pass[%0d]", i), int'({rx_vld5, ign5, rx_bit5, err5}), 10);
    end

    // Transmit stuff insertion with ready/valid
    tx_en5 = 1'b1; idx = 0;
    for (int s = 0; s < 8; s++) begin
      tx_vld5 = (idx < 7);
      tx_bit5 = (idx < 7) ? q3[idx][0] : 1'b0;
      rdy_b = rdy5;
      strobe();
      check($sformatf("tx_ready[%0d]", s), int'(rdy_b), (s == 5) ? 0 : 1);
      check($sformatf("tx_serial[%0d]", s), int'(ser5), s3[s]);
      check($sformatf("tx_stuffed[%0d]", s), int'(stf5), (s == 5) ? 1 : 0);
      if (rdy_b && tx_vld5) idx++;
    end
    check("tx_consumed", idx, 7);
    tx_vld5 = 1'b0; idle(2);
    check("tx_hold", int'(ser5), 0);
    tx_en5 = 1'b0;

    // RUN_LEN=3 chained stuffing, looped back into the receiver
    tx_en3 = 1'b1; idx = 0; ign_cnt = 0;
    for (int s = 0; s < 8; s++) begin
      rx_en3  = (s >= 1);
      tx_vld3 = (idx < 5);
      tx_bit3 = (idx < 5) ? q4[idx][0] : 1'b0;
      rdy_b = rdy3;
      strobe();
      check($sformatf("r3_serial[%0d]", s), int'(ser3), s4[s]);
      check($sformatf("r3_stuffed[%0d]", s), int'(stf3), (s == 3 || s == 6) ? 1 : 0);
      if (s >= 1) begin
        check($sformatf("r3_rx[%0d]", s), int'({rx_vld3, ign3, rx_vld3 & rx_bit3}), r4[s]);
        if (ign3) ign_cnt++;
      end
      if (rdy_b && tx_vld3) idx++;
    end
    check("r3_ignores", ign_cnt, 2);
    check("r3_rx_err", int'(err3), 0);
    {rx_en3, tx_en3, tx_vld3} = '0;

    // Reset mid-run returns outputs asynchronously
    rx_en5 = 1'b1; rx_ser5 = 1'b0;
    repeat (6) strobe();
    check("mid_err_set", int'(err5), 1);
    tx_en5 = 1'b1; tx_vld5 = 1'b1; tx_bit5 = 1'b0;
    repeat (4) strobe();
    check("mid_serial_pre", int'(ser5), 0);
    @(negedge r_Clock); rst = 1'b1; #1;
    check("mid_rst_serial", int'(ser5), 1);
    check("mid_rst_ready",  int'(rdy5), 1);
    check("mid_rst_err",    int'(err5), 0);
    @(negedge r_Clock); rst = 1'b0;
    @(posedge r_Clock); #1;
    for (int s = 0; s < 6; s++) begin
      strobe();
      check($sformatf("post_rst[%0d]", s), int'({stf5, ser5}), (s == 5) ? 3 : 0);
    end
    {rx_en5, tx_en5, tx_vld5} = '0;

`ifdef CAN_STUFF_COUNT_EN
    // Saturating stuff counters
    @(negedge r_Clock); rst = 1'b1;
    @(negedge r_Clock); rst = 1'b0;
    @(posedge r_Clock); #1;
    tx_en3 = 1'b1; rx_en3 = 1'b1; tx_vld3 = 1'b1; tx_bit3 = 1'b0;
    repeat (4) strobe();
    check("cnt_tx_first", int'(txc3), 1);
    repeat (1196) strobe();
    check("cnt_tx_sat", int'(txc3), 255);
    check("cnt_rx_sat", int'(rxc3), 255);
    {tx_en3, rx_en3, tx_vld3} = '0; idle(1);
    tx_en3 = 1'b1; rx_en3 = 1'b1; idle(1);
    check("cnt_tx_clr", int'(txc3), 0);
    check("cnt_rx_clr", int'(rxc3), 0);
    {tx_en3, rx_en3} = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
